// File: rtl/bch_msg_deframer.sv
// Serial-to-parallel deframer for corrected BCH codewords: keeps the K message
// bits of each N-bit codeword and queues them in a small FIFO for consumers.
module bch_msg_deframer #(
  parameter int N     = 63,
  parameter int K     = 51,
  parameter int DEPTH = 2,
  parameter int STALL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_data,
  output logic         in_ready,
  input  logic         resync,
  output logic [K-1:0] msg_data,
  output logic         msg_valid,
  input  logic         msg_ready,
  output logic [15:0]  frame_cnt,
  output logic [15:0]  drop_cnt
);

  localparam int CW = $clog2(N);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST  = CW'(N - 1);
  localparam logic [CW-1:0] KLIM  = CW'(K);
  localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);
  localparam logic [FW-1:0] FULL  = FW'(DEPTH);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PLAST) ? '0 : p + PW'(1);
  endfunction

  logic [CW-1:0] r_bcnt;
  logic [K-1:0]  r_sr;
  logic [K-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [FW-1:0] r_fill;
  logic [15:0]   r_frame;
  logic [15:0]   r_drop;

  logic w_pop;
  logic w_space;
  logic w_last;
  logic w_accept;
  logic w_complete;
  logic w_push;
  logic w_drop;

  // A pop in the same cycle frees a slot, so a full FIFO can still take the word.
  assign w_pop      = (r_fill != '0) && msg_ready;
  assign w_space    = (r_fill != FULL) || w_pop;
  assign w_last     = (r_bcnt == LAST);
  assign in_ready   = (STALL != 0) ? (!w_last || w_space) : 1'b1;
  assign w_accept   = in_valid && in_ready && !resync;
  assign w_complete = w_accept && w_last;
  assign w_push     = w_complete && w_space;
  assign w_drop     = w_complete && !w_space;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcnt  <= '0;
      r_sr    <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_fill  <= '0;
      r_frame <= '0;
      r_drop  <= '0;
    end else begin
      if (resync) begin
        r_bcnt <= '0;
        r_sr   <= '0;
      end else if (w_accept) begin
        r_bcnt <= w_last ? '0 : r_bcnt + CW'(1);
        if (r_bcnt < KLIM) r_sr <= {r_sr[K-2:0], in_data};
      end
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_push && !w_pop)      r_fill <= r_fill + FW'(1);
      else if (!w_push && w_pop) r_fill <= r_fill - FW'(1);
      if (w_complete) r_frame <= r_frame + 16'd1;
      if (w_drop)     r_drop  <= sat_inc16(r_drop);
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wr] <= r_sr;
  end

  assign msg_valid = (r_fill != '0);
  assign msg_data  = msg_valid ? r_mem[r_rd] : '0;
  assign frame_cnt = r_frame;
  assign drop_cnt  = r_drop;

endmodule
